// File: rtl/clifford_term_issuer.sv
// clifford_term_issuer: holds two FP32 multivector operand banks and streams
// every (i, j) blade-pair term of their geometric product into the clifford
// MAC pipeline, one term per cycle. It then waits for the pipeline to drain
// and pulses done.
module clifford_term_issuer #(
  parameter int GA_DIM       = 32,
  parameter int BLADE_W      = 5,
  parameter bit SKIP_ZERO    = 1'b1,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [BLADE_W-1:0] wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               term_valid,
  output logic [BLADE_W-1:0] term_blade_i,
  output logic [BLADE_W-1:0] term_blade_j,
  output logic [31:0]        term_coeff_a,
  output logic [31:0]        term_coeff_b,
  output logic               term_last,
  output logic [CNT_W-1:0]   term_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [BLADE_W-1:0] LAST_IDX  = BLADE_W'(GA_DIM - 1);
  localparam logic [DW-1:0]      DRAIN_MAX = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [BLADE_W-1:0] i_q, i_d, j_q, j_d;
  logic [DW-1:0]      drainCnt_q, drainCnt_d;
  logic               termValid_q, termValid_d;
  logic               termLast_q, termLast_d;
  logic [BLADE_W-1:0] bladeI_q, bladeI_d, bladeJ_q, bladeJ_d;
  logic [31:0]        coeffA_q, coeffA_d, coeffB_q, coeffB_d;
  logic [CNT_W-1:0]   termCount_q, termCount_d;

  logic [31:0] bankA [GA_DIM];
  logic [31:0] bankB [GA_DIM];
  logic [31:0] curA;
  logic        rowZero;

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  assign curA    = bankA[i_q];
  // A +0 or -0 row coefficient contributes nothing, so the whole row can go.
  assign rowZero = SKIP_ZERO && (curA[30:0] == 31'd0);

  // Operand banks are plain storage with no reset; they accept writes only while no pass is running.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (wr_sel) bankB[wr_addr] <= wr_data;
      else        bankA[wr_addr] <= wr_data;
    end
  end

  // State and registered term outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      drainCnt_q  <= '0;
      termValid_q <= 1'b0;
      termLast_q  <= 1'b0;
      bladeI_q    <= '0;
      bladeJ_q    <= '0;
      coeffA_q    <= '0;
      coeffB_q    <= '0;
      termCount_q <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      drainCnt_q  <= drainCnt_d;
      termValid_q <= termValid_d;
      termLast_q  <= termLast_d;
      bladeI_q    <= bladeI_d;
      bladeJ_q    <= bladeJ_d;
      coeffA_q    <= coeffA_d;
      coeffB_q    <= coeffB_d;
      termCount_q <= termCount_d;
    end
  end

  // Next state: walk (i, j) in row-major order, skipping zero rows and holding on stall.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    drainCnt_d  = drainCnt_q;
    termValid_d = 1'b0;
    termLast_d  = 1'b0;
    bladeI_d    = bladeI_q;
    bladeJ_d    = bladeJ_q;
    coeffA_d    = coeffA_q;
    coeffB_d    = coeffB_q;
    termCount_d = termCount_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d         = '0;
          j_d         = '0;
          termCount_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (rowZero) begin
            i_d = i_q + BLADE_W'(1);
            j_d = '0;
            if (i_q == LAST_IDX) state_d = DRAIN;
          end else begin
            termValid_d = 1'b1;
            bladeI_d    = i_q;
            bladeJ_d    = j_q;
            coeffA_d    = curA;
            coeffB_d    = bankB[j_q];
            termLast_d  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
            termCount_d = termCount_q + CNT_W'(1);
            j_d         = j_q + BLADE_W'(1);
            if (j_q == LAST_IDX) begin
              i_d = i_q + BLADE_W'(1);
              if (i_q == LAST_IDX) state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == DRAIN_MAX) begin
          drainCnt_d = '0;
          state_d    = DONE;
        end else begin
          drainCnt_d = drainCnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign term_valid   = termValid_q;
  assign term_last    = termLast_q;
  assign term_blade_i = bladeI_q;
  assign term_blade_j = bladeJ_q;
  assign term_coeff_a = coeffA_q;
  assign term_coeff_b = coeffB_q;
  assign term_count   = termCount_q;

endmodule

// File: tb/tb_clifford_term_issuer.sv
// Testbench for clifford_term_issuer: directed passes that are checked
// against a bench-side bank model. The expected term sequence is built from
// that model.
module tb_clifford_term_issuer;

  localparam int GA = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        stall = 1'b0;

  logic        busy, done, tv, tl;
  logic [4:0]  bi, bj;
  logic [31:0] ca, cb;
  logic [10:0] cnt;
  logic        busy0, done0, tv0, tl0;
  logic [4:0]  bi0, bj0;
  logic [31:0] ca0, cb0;
  logic [10:0] cnt0;

  logic        selDut0 = 1'b0;
  logic        mBusy, mDone, mValid, mLast;
  logic [4:0]  mBi, mBj;
  logic [31:0] mCa, mCb;
  logic [10:0] mCount;

  logic [31:0] modelA [GA];
  logic [31:0] modelB [GA];

  int checkCount = 0;
  int failCount  = 0;

  int rTerms, rLast, rSeqErr, rFirstK, rLastK, rDoneK, rGap, rBusy0, rBusyAtDone, rCount;
  bit rDoneSeen;

  clifford_term_issuer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stall(stall), .busy(busy), .done(done),
    .term_valid(tv), .term_blade_i(bi), .term_blade_j(bj), .term_coeff_a(ca),
    .term_coeff_b(cb), .term_last(tl), .term_count(cnt)
  );

  clifford_term_issuer #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start0), .stall(stall), .busy(busy0), .done(done0),
    .term_valid(tv0), .term_blade_i(bi0), .term_blade_j(bj0), .term_coeff_a(ca0),
    .term_coeff_b(cb0), .term_last(tl0), .term_count(cnt0)
  );

  always #5 clk = ~clk;

  // Route whichever instance is under test to the monitor signals.
  always_comb begin
    mBusy  = selDut0 ? busy0 : busy;
    mDone  = selDut0 ? done0 : done;
    mValid = selDut0 ? tv0   : tv;
    mLast  = selDut0 ? tl0   : tl;
    mBi    = selDut0 ? bi0   : bi;
    mBj    = selDut0 ? bj0   : bj;
    mCa    = selDut0 ? ca0   : ca;
    mCb    = selDut0 ? cb0   : cb;
    mCount = selDut0 ? cnt0  : cnt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input int addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 5'(addr);
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) modelB[addr] = data;
    else     modelA[addr] = data;
  endtask

  task automatic loadBanks(input logic [31:0] aVal, input logic [31:0] bVal);
    for (int k = 0; k < GA; k++) begin
      applyStimulus(1'b0, k, aVal);
      applyStimulus(1'b1, k, bVal);
    end
  endtask

  // One full pass: pulse start, then sample each cycle after the edge until done or the budget runs out.
  task automatic runPass(input bit onDut0, input bit skip, input int stallAt, input int injectK);
    int expI[$];
    int expJ[$];
    int idx;
    int stallLeft;
    for (int i = 0; i < GA; i++) begin
      if (!(skip && modelA[i][30:0] == 31'd0)) begin
        for (int j = 0; j < GA; j++) begin
          expI.push_back(i);
          expJ.push_back(j);
        end
      end
    end
    idx = 0; stallLeft = 0;
    rTerms = 0; rLast = 0; rSeqErr = 0; rFirstK = -1; rLastK = -1; rDoneK = -1;
    rGap = 0; rBusy0 = 0; rBusyAtDone = 1; rCount = 0; rDoneSeen = 1'b0;
    selDut0 = onDut0;
    if (onDut0) start0 = 1'b1;
    else        start  = 1'b1;
    for (int k = 0; k < 3000 && !rDoneSeen; k++) begin
      @(posedge clk); #1;
      start = 1'b0; start0 = 1'b0; wr_en = 1'b0;
      if (k == 0) rBusy0 = int'(mBusy);
      if (mValid) begin
        if (idx < expI.size()) begin
          if (int'(mBi) != expI[idx] || int'(mBj) != expJ[idx]) rSeqErr++;
          if (mCa !== modelA[expI[idx]] || mCb !== modelB[expJ[idx]]) rSeqErr++;
          if (mLast != (expI[idx] == GA-1 && expJ[idx] == GA-1)) rSeqErr++;
        end else begin
          rSeqErr++;
        end
        if (mLast) rLast++;
        idx++;
        rTerms++;
        if (rFirstK < 0) rFirstK = k;
        rLastK = k;
        if (idx == stallAt) stallLeft = 5;
      end else if (idx > 0 && idx < expI.size()) begin
        rGap++;
      end
      if (stallLeft > 0) begin
        stall = 1'b1;
        stallLeft--;
      end else begin
        stall = 1'b0;
      end
      if (k == injectK) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        if (onDut0) start0 = 1'b1;
        else        start  = 1'b1;
      end
      if (mDone) begin
        rDoneSeen   = 1'b1;
        rDoneK      = k;
        rBusyAtDone = int'(mBusy);
        rCount      = int'(mCount);
      end
    end
    stall = 1'b0; wr_en = 1'b0; start = 1'b0; start0 = 1'b0;
    if (!rDoneSeen) checkOutput("doneTimeout", 32'd0, 32'd1);
    checkOutput("seqErrors", rSeqErr, 0);
    checkOutput("termCountAtDone", rCount, rTerms);
    checkOutput("busyAtDone", rBusyAtDone, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    int k;
    bit doneDuringReset;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstValid", tv, 0);
    checkOutput("rstLast", tl, 0);
    checkOutput("rstCount", cnt, 0);
    checkOutput("rstBladeI", bi, 0);
    checkOutput("rstCoeffB", cb, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] full pass, all ones");
    loadBanks(32'h3F800000, 32'h3F800000);
    runPass(1'b0, 1'b1, -1, -1);
    checkOutput("fullTerms", rTerms, 1024);
    checkOutput("fullLastCount", rLast, 1);
    checkOutput("fullFirstK", rFirstK, 1);
    checkOutput("fullLastK", rLastK, 1024);
    checkOutput("fullDoneGap", rDoneK - rLastK, 3);
    checkOutput("fullBusyAt0", rBusy0, 1);
    checkOutput("fullGap", rGap, 0);
    checkOutput("fullCountHeld", cnt, 1024);

    $display("[TB] guarded start/write during ISSUE");
    runPass(1'b0, 1'b1, -1, 5);
    checkOutput("guardTerms", rTerms, 1024);
    checkOutput("guardDoneK", rDoneK, 1027);

    $display("[TB] stall at (7,12)");
    runPass(1'b0, 1'b1, 7*32+12, -1);
    checkOutput("stallTerms", rTerms, 1024);
    checkOutput("stallGap", rGap, 5);
    checkOutput("stallDoneK", rDoneK, 1032);

    $display("[TB] zero-row skip");
    loadBanks(32'h00000000, 32'h3F800000);
    applyStimulus(1'b0, 3, 32'h40000000);
    applyStimulus(1'b0, 31, 32'h80000000);
    runPass(1'b0, 1'b1, -1, -1);
    checkOutput("skipTerms", rTerms, 32);
    checkOutput("skipLastCount", rLast, 0);
    checkOutput("skipCount", rCount, 32);
    checkOutput("skipBladeI", bi, 3);
    checkOutput("skipCoeffA", ca, 32'h40000000);

    $display("[TB] SKIP_ZERO=0 with zero A");
    loadBanks(32'h00000000, 32'h3F800000);
    runPass(1'b1, 1'b0, -1, -1);
    checkOutput("noSkipTerms", rTerms, 1024);
    checkOutput("noSkipLastCount", rLast, 1);
    checkOutput("noSkipCoeffA", ca0, 32'h0);
    selDut0 = 1'b0;

    $display("[TB] reset mid-pass");
    loadBanks(32'h3F800000, 32'h3F800000);
    start = 1'b1;
    seen = 0; k = 0;
    while (seen < 500 && k < 2000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tv) seen++;
      k++;
    end
    checkOutput("rstMidReach", seen, 500);
    checkOutput("rstMidCountBefore", cnt, 500);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidValid", tv, 0);
    checkOutput("rstMidCount", cnt, 0);
    checkOutput("rstMidBladeJ", bj, 0);
    checkOutput("rstMidCoeffA", ca, 0);
    doneDuringReset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (done) doneDuringReset = 1'b1;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (done) doneDuringReset = 1'b1;
    end
    checkOutput("rstMidNoDone", doneDuringReset, 0);
    runPass(1'b0, 1'b1, -1, -1);
    checkOutput("afterRstTerms", rTerms, 1024);
    checkOutput("afterRstLastCount", rLast, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
